// File: rtl/demux_pkg.sv
// Shared types and header-field helpers for the demux routing controller.
package demux_pkg;

    typedef enum logic [1:0] {
        StHdr,
        StFwd,
        StDrop
    } state_e;

    // Destination sits in the low bits of the header; length follows it.
    localparam int unsigned DestLsb = 0;

    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_obuf.sv
// Single-entry output holding register with load/take handshake.
module demux_obuf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              take_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    // A load wins over a take so a same-cycle replace keeps valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (take_i) begin
            data_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_route_ctrl.sv
// Header-decoding packet router steering a word stream to one of N_OUT sinks.
module demux_route_ctrl
    import demux_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned N_OUT  = 4,
    parameter  int unsigned LEN_W  = 4,
    localparam int unsigned SEL_W  = sel_w(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              pkt_done,
    output logic              err
);

    localparam int unsigned LenLsb = DestLsb + SEL_W;

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              pkt_done_q;
    logic              err_q;

    logic [SEL_W-1:0]  hdr_dest;
    logic [LEN_W-1:0]  hdr_len;
    logic              dest_ok;
    logic              obuf_valid;
    logic              accept;
    logic              take;
    logic              load;

    assign hdr_dest = in_data[DestLsb +: SEL_W];
    assign hdr_len  = in_data[LenLsb +: LEN_W];
    assign dest_ok  = 32'(hdr_dest) < N_OUT;

    assign take   = obuf_valid && out_ready[sel_q];
    assign accept = in_valid && in_ready;
    assign load   = accept && (state_q == StFwd);

    // HDR waits for an empty register so sel never moves under held data.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StHdr:   in_ready = !obuf_valid;
            StFwd:   in_ready = !obuf_valid || out_ready[sel_q];
            StDrop:  in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHdr;
            sel_q      <= '0;
            cnt_q      <= '0;
            pkt_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            err_q      <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    StHdr: begin
                        if (!dest_ok) begin
                            err_q <= 1'b1;
                            if (hdr_len != '0) begin
                                cnt_q   <= hdr_len;
                                state_q <= StDrop;
                            end
                        end else if (hdr_len == '0) begin
                            pkt_done_q <= 1'b1;
                        end else begin
                            sel_q   <= hdr_dest;
                            cnt_q   <= hdr_len;
                            state_q <= StFwd;
                        end
                    end
                    StFwd: begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            pkt_done_q <= 1'b1;
                            state_q    <= StHdr;
                        end
                    end
                    StDrop: begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= StHdr;
                        end
                    end
                    default: state_q <= StHdr;
                endcase
            end
        end
    end

    demux_obuf #(
        .DATA_W(DATA_W)
    ) u_obuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .take_i (take),
        .data_i (in_data),
        .data_o (out_data),
        .valid_o(obuf_valid)
    );

    always_comb begin
        out_valid = '0;
        if (obuf_valid) begin
            out_valid[sel_q] = 1'b1;
        end
    end

    assign sel      = sel_q;
    assign busy     = (state_q != StHdr) || obuf_valid;
    assign pkt_done = pkt_done_q;
    assign err      = err_q;

endmodule

// File: doc/demux_route_ctrl.md
# demux_route_ctrl

Packet-routing controller for the 1:N demultiplexer datapath. It accepts a valid/ready word stream, decodes a one-word header carrying destination index and payload length, and steers the payload to one of N_OUT sinks. A registered output stage provides per-sink backpressure. It also owns the demux select, so no requester drives `sel` directly.

## Interface
- `DATA_W`, 8: word width; must be ≥ SEL_W + LEN_W.
- `N_OUT`, 4: number of sinks; a power of two, ≥ 2.
- `LEN_W`, 4: payload-length field width; maximum payload is 2^LEN_W − 1 words.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  DATA_W  input word.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `out_data`  out  DATA_W  shared output word, driven from the output register.
- `out_valid`  out  N_OUT  one-hot valid, bit `sel` only.
- `out_ready`  in  N_OUT  per-sink ready.
- `sel`  out  SEL_W=$clog2(N_OUT)  current destination.
- `busy`  out  1  high when state ≠ HDR or the output register is full.
- `pkt_done`  out  1  one-cycle pulse at packet end.
- `err`  out  1  one-cycle pulse when a bad destination is dropped.

## Operation
- Accept: a word is accepted when `in_valid && in_ready`. An output word is taken when `out_valid[sel] && out_ready[sel]`.
- Header layout: `dest = in_data[SEL_W-1:0]`, `len = in_data[SEL_W+LEN_W-1:SEL_W]`. Upper bits are ignored.
- The header is consumed by the controller and never forwarded.
- FSM states: HDR, FWD, DROP.
- HDR:
  - `in_ready` = output register empty, so `sel` never changes under held data.
  - On header accept with `dest < N_OUT` and `len > 0`: `sel <= dest`, `cnt <= len`, go to FWD.
  - `len == 0`: stay in HDR and pulse `pkt_done`.
  - `dest ≥ N_OUT`: pulse `err`. With `len > 0`, load `cnt` and go to DROP; with `len == 0`, stay in HDR.
  - `dest ≥ N_OUT` is only possible when N_OUT is not a power of two; the check is still kept.
- FWD:
  - `in_ready = !obuf_valid || out_ready[sel]`, so back-to-back throughput is one word per cycle.
  - Each accepted word is loaded into the output register and `cnt` decrements.
  - On accepting the word with `cnt == 1`: pulse `pkt_done` and go to HDR.
- DROP:
  - `in_ready = 1`; words are discarded and `cnt` decrements.
  - At `cnt == 1`, go to HDR. No `pkt_done` pulse.
- Output register:
  - Loaded on accept.
  - Cleared on a take with no simultaneous load.
  - A simultaneous take and load replaces the contents; valid stays high.
- Unselected bits of `out_valid` are always 0. `out_ready` on non-selected sinks is ignored.
- `cnt` is LEN_W bits and never wraps below 1 while in FWD/DROP.

## Timing
- Reset values: `in_ready` 1 (HDR, register empty), `out_valid` 0, `out_data` 0, `sel` 0, `busy` 0, `pkt_done` 0, `err` 0, `cnt` 0, state HDR.
- Reset is asynchronous and mid-packet. All state clears immediately. Held and in-flight words are lost, and no pulse is emitted.
- Latency: a payload word accepted at edge t is visible on `out_data`/`out_valid` after edge t, i.e. one cycle.
- `sel` changes at the edge that accepts the header. The first payload can be accepted in the next cycle.
- `pkt_done` and `err` are registered. Each is high for exactly the one cycle following the accepting edge.
- Back-to-back packets to different sinks incur one bubble, because HDR waits for the last word to drain.
- `in_ready` is combinational from state, `obuf_valid`, `out_ready` and `sel`. `out_*` are register outputs.
- When `out_ready[sel]` stays low, the held word and `out_valid` stay stable and `in_ready` is 0.

## Structure
- Package `demux_pkg`: state enum (HDR, FWD, DROP), header field offset localparams, and a `sel_w(N)` function.
- Sub-module `demux_obuf`: a single-entry holding register with load/take/valid. It is parameterised by DATA_W and instantiated once.
- The FSM, counter, decode and one-hot valid logic stay in `demux_route_ctrl`.

## Test plan
All cases use the defaults N_OUT=4, LEN_W=4.
- Reset, then a header with dest=2 and len=3, then payload A1,A2,A3 with all sinks ready:
  - `sel`=2 and `out_valid`=4'b0100 for 3 consecutive cycles, carrying A1..A3.
  - `pkt_done` pulses once.
- Hold `out_ready[1]`=0 for 5 cycles mid-packet to dest 1:
  - `out_data` is held stable and `in_ready`=0.
  - On release, the remaining words arrive in order with none lost or duplicated.
- Header with dest=3 and len=0: `pkt_done` pulses the next cycle, `out_valid` stays 0, and the state stays HDR.
- Packet to dest 0 (len 2) immediately followed by a header to dest 3:
  - The second header waits until the register drains.
  - `sel` goes 0→3 only after the last dest-0 word is taken.
- Force N_OUT=3 and send dest=3 with len=2: `err` pulses, 2 words are consumed, no `out_valid` is asserted, and no `pkt_done` pulse.
- Assert `rst_n`=0 mid-FWD with a word held: all outputs take their reset values asynchronously, and the next header routes normally.
